geo_series_seq: RTL

- Sequencer that sits directly upstream of the exponent unit (x^n, INIT/COND/ITER FSM).
- Accepts one (x, n_max) job and issues x^0, x^1 … x^n_max to the exponent unit one at a time.
- Consumes each result and accumulates the geometric series sum S = Σ x^k for k = 0..n_max.
- Includes saturation, a sticky overflow flag and a per-request watchdog.

---
 rtl/geo_series_seq_if.sv | 30 +++
 rtl/geo_series_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/geo_series_seq_if.sv
// Handshake bundle between the geometric-series sequencer and the exponent unit.
//   master (sequencer): drives exp_start / exp_x / exp_n, receives exp_done / exp_result
//   slave  (exp unit) : receives the request, returns the result-valid pulse and result
interface geo_series_seq_if #(
    parameter int unsigned XW = 8,
    parameter int unsigned NW = 4,
    parameter int unsigned RW = 16
);
    logic          exp_start;
    logic [XW-1:0] exp_x;
    logic [NW-1:0] exp_n;
    logic          exp_done;
    logic [RW-1:0] exp_result;

    modport master (
        output exp_start,
        output exp_x,
        output exp_n,
        input  exp_done,
        input  exp_result
    );

    modport slave (
        input  exp_start,
        input  exp_x,
        input  exp_n,
        output exp_done,
        output exp_result
    );
endinterface

// File: rtl/geo_series_seq.sv
// Geometric-series sequencer. Takes one (x, n_max) job, asks the exponent unit for
// x^0 .. x^n_max one term at a time and accumulates S = sum of those terms with
// saturation. A per-request watchdog aborts the job if the exponent unit stalls.
//   clk, rst      : clock (rising edge), asynchronous active-low reset
//   start_i       : job request, only honoured in IDLE; x_i / n_max_i captured with it
//   busy_o        : job in progress (cycle after accepted start through FINISH)
//   done_o        : one-cycle completion pulse (normal or aborted)
//   sum_o         : accumulated sum, held until the next accepted start
//   overflow_o    : sticky per job, sum saturated
//   timeout_o     : sticky per job, watchdog expired
//   exp_if        : request/response handshake to the exponent unit (master side)
module geo_series_seq #(
    parameter int unsigned XW  = 8,
    parameter int unsigned NW  = 4,
    parameter int unsigned RW  = 16,
    parameter int unsigned SW  = 20,
    parameter int unsigned TMO = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [XW-1:0]         x_i,
    input  logic [NW-1:0]         n_max_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [SW-1:0]         sum_o,
    output logic                  overflow_o,
    output logic                  timeout_o,
    geo_series_seq_if.master      exp_if
);

    localparam int unsigned WdW = (TMO < 2) ? 1 : $clog2(TMO + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StIssue  = 3'd1;
    localparam logic [2:0] StWait   = 3'd2;
    localparam logic [2:0] StAccum  = 3'd3;
    localparam logic [2:0] StFinish = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [NW-1:0]  n_q, n_d;
    logic [NW-1:0]  k_q, k_d;
    logic [RW-1:0]  r_q, r_d;
    logic [SW-1:0]  sum_q, sum_d;
    logic           ovf_q, ovf_d;
    logic           tmo_q, tmo_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic [XW-1:0]  exp_x_q, exp_x_d;
    logic [NW-1:0]  exp_n_q, exp_n_d;

    // One extra bit so the carry out of the add flags saturation.
    logic [SW:0]    sum_ext;

    assign sum_ext = {1'b0, sum_q} + {{(SW + 1 - RW){1'b0}}, r_q};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        n_d     = n_q;
        k_d     = k_q;
        r_d     = r_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
        wd_d    = wd_q;
        exp_x_d = exp_x_q;
        exp_n_d = exp_n_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    x_d     = x_i;
                    n_d     = n_max_i;
                    k_d     = '0;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                    // Request operands are loaded on entry so they are valid during ISSUE.
                    exp_x_d = x_i;
                    exp_n_d = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                if (exp_if.exp_done) begin
                    r_d     = exp_if.exp_result;
                    state_d = StAccum;
                end else if (wd_q == WdW'(TMO - 1)) begin
                    // This is the TMO-th cycle without a result.
                    tmo_d   = 1'b1;
                    state_d = StFinish;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end
            end
            StAccum: begin
                if (sum_ext[SW]) begin
                    sum_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    sum_d = sum_ext[SW-1:0];
                end
                // Compare before incrementing so k never wraps at n_max = all ones.
                if (k_q == n_q) begin
                    state_d = StFinish;
                end else begin
                    k_d     = k_q + NW'(1);
                    exp_x_d = x_q;
                    exp_n_d = k_q + NW'(1);
                    state_d = StIssue;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            wd_q    <= '0;
            exp_x_q <= '0;
            exp_n_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            n_q     <= n_d;
            k_q     <= k_d;
            r_q     <= r_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            wd_q    <= wd_d;
            exp_x_q <= exp_x_d;
            exp_n_q <= exp_n_d;
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StFinish);
    assign sum_o      = sum_q;
    assign overflow_o = ovf_q;
    assign timeout_o  = tmo_q;

    assign exp_if.exp_start = (state_q == StIssue);
    assign exp_if.exp_x     = exp_x_q;
    assign exp_if.exp_n     = exp_n_q;

endmodule
